packet_rate_scheduler: RTL
==========================

Name: packet_rate_scheduler

Overview:
Parametrised packet-launch scheduler in the nibble_clk domain. It generates one-cycle start_sending pulses for the Ethernet TX path at a selectable rate: a 16-entry table or a custom period. Supports continuous, burst-of-N and single-shot modes. Holds back launches while the transmitter reports busy and counts the ticks it has to drop.

Parameters:
CNT_W, 25, width of period counter and custom_period
BURST_W, 8, width of burst_len and remaining-packet counter
SENT_W, 32, width of sent_count
DROP_W, 16, width of drop_count (saturating)

Ports:
nibble_clk  in  1  sole clock (25 MHz TX nibble clock)
rstn  in  1  synchronous active-low reset
mode  in  2  0 OFF, 1 CONTINUOUS, 2 BURST, 3 SINGLE
rate_sel  in  4  table index; table value is period-1
use_custom  in  1  1: use custom_period instead of table
custom_period  in  CNT_W  custom period-1 in nibble_clk cycles
burst_len  in  BURST_W  packets per arm in BURST mode
arm  in  1  one-cycle start request for BURST/SINGLE; ignored otherwise
tx_busy  in  1  transmitter busy; a launch is not permitted while high
start_sending  out  1  one-cycle launch pulse
active  out  1  scheduler running (CONTINUOUS, or FSM in RUN)
done  out  1  one-cycle pulse when a BURST/SINGLE sequence completes
sent_count  out  SENT_W  total launches, wraps
drop_count  out  DROP_W  ticks dropped due to overrun, saturates at all-ones

Behaviour:
- Clock and reset: one clock, nibble_clk. Reset is synchronous and active-low on rstn.
- Reset: all outputs 0. count=0, max_count=0, pending=0, remaining=0, FSM=IDLE, mode_q=0.
- Rate table (period-1), indexed by rate_sel 0..15: 24999999, 12499999, 2499999, 1249999, 499999, 249999, 124999, 49999, 24999, 12499, 4999, 2499, 999, 499, 249, 0. Table values wider than CNT_W are truncated.
- max_count register: loaded every cycle with use_custom ? custom_period : table[rate_sel]. One cycle of latency from input change.
- Tick: when the scheduler is enabled, count increments each cycle. When count>=max_count, count is set to 0 and tick=1 for that cycle. Using >= means shrinking the period mid-count terminates the current period on the next cycle. max_count=0 gives a tick every cycle.
- Launch rule: start_sending=1 in a cycle when (tick|pending) & !tx_busy & enabled.
  - If tx_busy is high, a tick sets pending=1.
  - A tick while pending is already 1 and tx_busy is high increments drop_count. At most one pending launch is held.
  - pending clears on launch.
  - start_sending is registered: it is asserted the cycle after the qualifying condition.
- sent_count increments on every start_sending.
- CONTINUOUS: enabled whenever mode==1. active=1. done is never asserted.
- BURST/SINGLE FSM, states IDLE and RUN:
  - IDLE + arm: go to RUN. Clear count. Set pending=1, so the first packet launches as soon as tx_busy is low.
  - remaining is loaded with burst_len (BURST) or 1 (SINGLE).
  - BURST with burst_len==0: stay in IDLE and pulse done next cycle, with no launch.
  - RUN: each launch decrements remaining. The launch that takes remaining to 0 returns the FSM to IDLE and pulses done in the same cycle as that start_sending.
  - After the final launch, ticks are ignored and nothing further is counted as dropped.
  - arm while in RUN is ignored.
- OFF: count holds at 0, pending=0, no launches.
- Mode change: any cycle where mode != mode_q (registered copy) forces the FSM to IDLE and clears count, pending and remaining. done is not pulsed. sent_count and drop_count are kept.
- Reset mid-operation: everything returns to reset values on the next edge. An in-flight start_sending pulse is not extended.
- Simultaneous events:
  - tick together with a pending launch produces a single launch, with no drop.
  - tx_busy rising in the same cycle as a qualifying condition blocks the launch; it becomes pending.

Test Plan:
- Reset, then mode=1, rate_sel=15, tx_busy=0 -> start_sending high every cycle from the 3rd cycle after release; sent_count=10 after 10 pulses.
- mode=1, use_custom=1, custom_period=4 -> pulses exactly 5 cycles apart; switching custom_period to 1 mid-period -> next pulse within 2 cycles, then every 2 cycles.
- mode=2, burst_len=3, custom_period=9, one arm pulse -> 3 pulses at t0, t0+10, t0+20; done coincides with the 3rd pulse; active falls; no further pulses.
- mode=1, custom_period=2, tx_busy held high for 10 cycles -> one launch the cycle after tx_busy falls; drop_count=2 or 3 matching tick count minus one; drop_count saturates at 65535 under long busy.
- mode=3, arm while tx_busy=1 -> no pulse until tx_busy low, then exactly one pulse plus done; a second arm during RUN is ignored.
- mode=2, burst_len=5, switch mode to 0 after 2 pulses -> no further pulses, done never asserted, sent_count=2; rstn low mid-burst -> all outputs 0 next edge.

Source files
------------

// File: rtl/packet_rate_scheduler.sv
// packet_rate_scheduler: paced start_sending pulses for the Ethernet TX path (continuous, burst-of-N, single-shot)
//   nibble_clk/rstn      : clock and synchronous active-low reset
//   mode                 : 0 off, 1 continuous, 2 burst, 3 single
//   rate_sel/use_custom  : period select from the rate table or custom_period (both hold period-1)
//   burst_len/arm        : packets per burst and the one-cycle start request for burst/single
//   tx_busy              : holds back launches; at most one launch is kept pending
//   start_sending/done   : one-cycle launch pulse / end-of-sequence pulse
//   active               : continuous mode or a burst/single sequence in progress
//   sent_count/drop_count: total launches (wrapping) / ticks lost to overrun (saturating)
module packet_rate_scheduler #(
    parameter int CNT_W   = 25,
    parameter int BURST_W = 8,
    parameter int SENT_W  = 32,
    parameter int DROP_W  = 16
) (
    input  logic               nibble_clk,
    input  logic               rstn,
    input  logic [1:0]         mode,
    input  logic [3:0]         rate_sel,
    input  logic               use_custom,
    input  logic [CNT_W-1:0]   custom_period,
    input  logic [BURST_W-1:0] burst_len,
    input  logic               arm,
    input  logic               tx_busy,
    output logic               start_sending,
    output logic               active,
    output logic               done,
    output logic [SENT_W-1:0]  sent_count,
    output logic [DROP_W-1:0]  drop_count
);
    localparam logic [1:0] MODE_CONT  = 2'd1;
    localparam logic [1:0] MODE_BURST = 2'd2;
    localparam logic [0:0] S_IDLE     = 1'b0;
    localparam logic [0:0] S_RUN      = 1'b1;

    function automatic logic [CNT_W-1:0] table_period(input logic [3:0] sel);
        logic [31:0] v;
        case (sel)
            4'd0:    v = 32'd24999999;
            4'd1:    v = 32'd12499999;
            4'd2:    v = 32'd2499999;
            4'd3:    v = 32'd1249999;
            4'd4:    v = 32'd499999;
            4'd5:    v = 32'd249999;
            4'd6:    v = 32'd124999;
            4'd7:    v = 32'd49999;
            4'd8:    v = 32'd24999;
            4'd9:    v = 32'd12499;
            4'd10:   v = 32'd4999;
            4'd11:   v = 32'd2499;
            4'd12:   v = 32'd999;
            4'd13:   v = 32'd499;
            4'd14:   v = 32'd249;
            default: v = 32'd0;
        endcase
        return CNT_W'(v);
    endfunction

    logic [1:0]         mode_q;
    logic [CNT_W-1:0]   max_count_q;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               pending_q, pending_d;
    logic [BURST_W-1:0] remaining_q, remaining_d;
    logic [0:0]         state_q, state_d;
    logic               start_q, done_q;
    logic [SENT_W-1:0]  sent_q, sent_d;
    logic [DROP_W-1:0]  drop_q, drop_d;
    logic               mode_chg, run, enabled, tick, launch, arm_ok, arm_zero, arm_go, last;

    always_comb begin
        mode_chg    = mode != mode_q;
        run         = state_q == S_RUN;
        enabled     = !mode_chg && (mode == MODE_CONT || (mode[1] && run));
        // >= so a period shrunk mid-count ends on the next cycle
        tick        = enabled && count_q >= max_count_q;
        launch      = enabled && (tick || pending_q) && !tx_busy;
        arm_ok      = !mode_chg && mode[1] && !run && arm;
        arm_zero    = arm_ok && mode == MODE_BURST && burst_len == '0;
        arm_go      = arm_ok && !arm_zero;
        last        = launch && run && remaining_q == BURST_W'(1);
        // every launch restarts the period, so the armed first packet and
        // a deferred packet are each followed by a full period
        count_d     = (!enabled || tick || launch) ? '0 : count_q + CNT_W'(1);
        pending_d   = arm_go || (enabled && !launch && (tick || pending_q));
        remaining_d = mode_chg ? '0 :
                      arm_go ? (mode == MODE_BURST ? burst_len : BURST_W'(1)) :
                      (launch && run) ? remaining_q - BURST_W'(1) : remaining_q;
        state_d     = (mode_chg || last) ? S_IDLE : arm_go ? S_RUN : state_q;
        // a tick that finds a launch already held while busy is lost
        drop_d      = (tick && tx_busy && pending_q && drop_q != '1) ? drop_q + DROP_W'(1) : drop_q;
        sent_d      = sent_q + SENT_W'(launch);
    end

    always_ff @(posedge nibble_clk) begin
        if (!rstn) begin
            mode_q      <= 2'd0;
            max_count_q <= '0;
            count_q     <= '0;
            pending_q   <= 1'b0;
            remaining_q <= '0;
            state_q     <= S_IDLE;
            start_q     <= 1'b0;
            done_q      <= 1'b0;
            sent_q      <= '0;
            drop_q      <= '0;
        end else begin
            mode_q      <= mode;
            max_count_q <= use_custom ? custom_period : table_period(rate_sel);
            count_q     <= count_d;
            pending_q   <= pending_d;
            remaining_q <= remaining_d;
            state_q     <= state_d;
            start_q     <= launch;
            done_q      <= last || arm_zero;
            sent_q      <= sent_d;
            drop_q      <= drop_d;
        end
    end

    assign start_sending = start_q;
    assign done          = done_q;
    assign active        = mode_q == MODE_CONT || state_q == S_RUN;
    assign sent_count    = sent_q;
    assign drop_count    = drop_q;
endmodule
